// File: rtl/spi_memory_burst_pkg.sv
// Shared state encoding and constants for the SPI burst memory slave.
package spi_memory_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CMD       = 3'd1,
    ST_RD_LOAD   = 3'd2,
    ST_RD_SHIFT  = 3'd3,
    ST_WR_SHIFT  = 3'd4,
    ST_WR_COMMIT = 3'd5
  } state_e;

  localparam logic READ = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_memory_burst_pin_sync.sv
// Pin synchroniser plus one-cycle edge detector. Flops are deliberately left
// unreset so a reset never fabricates an edge from a pin that is already low.
module spi_memory_burst_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], pin_i};
    prev_q <= sync_q[STAGES-1];
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave in front of a register-file memory with burst access.
// States: IDLE wait cs | CMD addr+rw | RD_LOAD fetch | RD_SHIFT tx | WR_SHIFT rx | WR_COMMIT store
module spi_memory_burst
  import spi_memory_burst_pkg::*;
#(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BURST_EN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic       busy,
  output logic [3:0] leds
);

  localparam int CMD_BITS = ADDR_WIDTH + 1;
  localparam int RXW      = max_int(CMD_BITS, DATA_WIDTH);
  localparam int CNT_W    = $clog2(RXW + 1);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_memory_burst_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .pin_i(sclk_pin), .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_memory_burst_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .pin_i(cs_pin), .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_memory_burst_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .pin_i(mosi_pin), .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign unused_sync = &{1'b0, sclk_lvl, cs_rise, mosi_rise, mosi_fall};

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [RXW-1:0]          rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic                    miso_q, miso_d;
  logic                    hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_WR_COMMIT) begin
      mem_q[addr_q] <= rx_q[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_CMD;
          cnt_d   = '0;
          hold_d  = 1'b0;
        end
      end
      ST_CMD: begin
        if (cs_lvl) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          rx_d = {rx_q[RXW-2:0], mosi_lvl};
          if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
            addr_d  = rx_q[ADDR_WIDTH-1:0];
            cnt_d   = '0;
            state_d = (mosi_lvl == READ) ? ST_RD_LOAD : ST_WR_SHIFT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RD_LOAD: begin
        if (cs_lvl) begin
          state_d = ST_IDLE;
        end else begin
          tx_d    = mem_q[addr_q];
          state_d = ST_RD_SHIFT;
        end
      end
      ST_RD_SHIFT: begin
        if (cs_lvl) begin
          state_d = ST_IDLE;
        end else begin
          if (sclk_fall) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
          // Without burst the drained shifter keeps feeding zeros.
          if (sclk_rise) begin
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              cnt_d = '0;
              if (BURST_EN != 0) begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = ST_RD_LOAD;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_WR_SHIFT: begin
        if (cs_lvl) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          rx_d = {rx_q[RXW-2:0], mosi_lvl};
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d = '0;
            if (!hold_q) state_d = ST_WR_COMMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WR_COMMIT: begin
        if (BURST_EN != 0) addr_d = addr_q + ADDR_WIDTH'(1);
        else               hold_d = 1'b1;
        state_d = cs_lvl ? ST_IDLE : ST_WR_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign miso_oe  = (state_q == ST_RD_LOAD) || (state_q == ST_RD_SHIFT);
  assign miso_pin = miso_oe ? miso_q : 1'bz;
  assign busy     = (state_q != ST_IDLE);
  assign leds     = {miso_oe, state_q};

endmodule

// File: tb/tb_spi_memory_burst.sv
// Directed bench: default, non-burst and 4/16-bit instances share sclk/mosi,
// each with its own chip select.
module tb_spi_memory_burst;

  localparam int HALF = 8;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic [2:0] cs = 3'b111;
  wire  [2:0] miso_w;
  wire  [2:0] oe_w;
  wire  [2:0] busy_w;
  wire  [3:0] leds0, leds1, leds2;

  int total = 0;
  int bad = 0;

  logic [15:0] wbuf [4];
  logic [15:0] rbuf [4];

  always #5 clk = ~clk;

  spi_memory_burst u_dut0 (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs[0]), .mosi_pin(mosi),
    .miso_pin(miso_w[0]), .miso_oe(oe_w[0]), .busy(busy_w[0]), .leds(leds0)
  );
  spi_memory_burst #(.BURST_EN(0)) u_dut1 (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs[1]), .mosi_pin(mosi),
    .miso_pin(miso_w[1]), .miso_oe(oe_w[1]), .busy(busy_w[1]), .leds(leds1)
  );
  spi_memory_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) u_dut2 (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs[2]), .mosi_pin(mosi),
    .miso_pin(miso_w[2]), .miso_oe(oe_w[2]), .busy(busy_w[2]), .leds(leds2)
  );

  task automatic spi_bit(input int sel, input logic mo, output logic mi, output logic oe);
    mosi = mo;
    repeat (HALF) @(posedge clk);
    #2;
    mi = miso_w[sel];
    oe = oe_w[sel];
    sclk = 1'b1;
    repeat (HALF) @(posedge clk);
    #2;
    sclk = 1'b0;
  endtask

  task automatic cs_set(input int sel, input logic v);
    repeat (HALF) @(posedge clk);
    #2;
    cs[sel] = v;
    repeat (HALF) @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input int sel, input int aw, input logic [15:0] addr,
                          input logic rw, output logic oe_seen);
    logic mi, oe;
    oe_seen = 1'b0;
    for (int i = aw - 1; i >= 0; i--) begin
      spi_bit(sel, addr[i], mi, oe);
      oe_seen = oe_seen | oe;
    end
    spi_bit(sel, rw, mi, oe);
    oe_seen = oe_seen | oe;
  endtask

  task automatic frame_write(input int sel, input int aw, input int dw,
                             input logic [15:0] addr, input int n);
    logic mi, oe, oe_cmd;
    cs_set(sel, 1'b0);
    send_cmd(sel, aw, addr, 1'b0, oe_cmd);
    for (int w = 0; w < n; w++)
      for (int b = dw - 1; b >= 0; b--)
        spi_bit(sel, wbuf[w][b], mi, oe);
    cs_set(sel, 1'b1);
  endtask

  task automatic frame_read(input int sel, input int aw, input int dw,
                            input logic [15:0] addr, input int n);
    logic mi, oe, oe_cmd;
    cs_set(sel, 1'b0);
    send_cmd(sel, aw, addr, 1'b1, oe_cmd);
    for (int w = 0; w < n; w++) begin
      rbuf[w] = '0;
      for (int b = 0; b < dw; b++) begin
        spi_bit(sel, 1'b0, mi, oe);
        rbuf[w] = {rbuf[w][14:0], mi};
      end
    end
    cs_set(sel, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (leds0 !== 4'h0 || leds1 !== 4'h0 || leds2 !== 4'h0) begin
      bad++;
      $display("FAIL reset_leds got=%h/%h/%h want=0", leds0, leds1, leds2);
    end
    total++;
    if (oe_w !== 3'b000) begin
      bad++;
      $display("FAIL reset_oe got=%b want=000", oe_w);
    end
    total++;
    if (busy_w !== 3'b000) begin
      bad++;
      $display("FAIL reset_busy got=%b want=000", busy_w);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_single_rw();
    logic [7:0] expv;
    logic mi, oe, oe_cmd, oe_all;
    expv = 8'hA5;
    wbuf[0] = 16'h00A5;
    frame_write(0, 7, 8, 16'h15, 1);
    cs_set(0, 1'b0);
    send_cmd(0, 7, 16'h15, 1'b1, oe_cmd);
    total++;
    if (oe_cmd !== 1'b0) begin
      bad++;
      $display("FAIL single_oe_cmd got=%b want=0", oe_cmd);
    end
    oe_all = 1'b1;
    for (int i = 0; i < 8; i++) begin
      spi_bit(0, 1'b0, mi, oe);
      oe_all = oe_all & oe;
      total++;
      if (mi !== expv[7-i]) begin
        bad++;
        $display("FAIL single_bit%0d got=%b want=%b", i, mi, expv[7-i]);
      end
    end
    total++;
    if (oe_all !== 1'b1) begin
      bad++;
      $display("FAIL single_oe_data got=%b want=1", oe_all);
    end
    cs_set(0, 1'b1);
    total++;
    if (oe_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_after got=oe%b busy%b want=0/0", oe_w[0], busy_w[0]);
    end
  endtask

  task automatic test_burst();
    wbuf[0] = 16'h0011;
    wbuf[1] = 16'h0022;
    wbuf[2] = 16'h0033;
    frame_write(0, 7, 8, 16'h7E, 3);
    frame_read(0, 7, 8, 16'h7E, 3);
    total++;
    if (rbuf[0] !== 16'h0011) begin bad++; $display("FAIL burst_w0 got=%h want=0011", rbuf[0]); end
    total++;
    if (rbuf[1] !== 16'h0022) begin bad++; $display("FAIL burst_w1 got=%h want=0022", rbuf[1]); end
    total++;
    if (rbuf[2] !== 16'h0033) begin bad++; $display("FAIL burst_w2 got=%h want=0033", rbuf[2]); end
    frame_read(0, 7, 8, 16'h00, 1);
    total++;
    if (rbuf[0] !== 16'h0033) begin bad++; $display("FAIL burst_wrap got=%h want=0033", rbuf[0]); end
  endtask

  task automatic test_abort();
    logic mi, oe, oe_cmd;
    int cyc;
    wbuf[0] = 16'h005C;
    frame_write(0, 7, 8, 16'h03, 1);
    cs_set(0, 1'b0);
    send_cmd(0, 7, 16'h03, 1'b0, oe_cmd);
    for (int i = 0; i < 5; i++) spi_bit(0, 1'b1, mi, oe);
    total++;
    if (busy_w[0] !== 1'b1) begin bad++; $display("FAIL abort_busy_pre got=%b want=1", busy_w[0]); end
    repeat (HALF) @(posedge clk);
    #1;
    cs[0] = 1'b1;
    cyc = 0;
    while (busy_w[0] === 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (cyc > SYNC + 2 || busy_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy_cycles got=%0d want<=%0d", cyc, SYNC + 2);
    end
    total++;
    if (oe_w[0] !== 1'b0) begin bad++; $display("FAIL abort_oe got=%b want=0", oe_w[0]); end
    repeat (HALF) @(posedge clk);
    frame_read(0, 7, 8, 16'h03, 1);
    total++;
    if (rbuf[0] !== 16'h005C) begin bad++; $display("FAIL abort_mem got=%h want=005C", rbuf[0]); end
  endtask

  task automatic test_no_burst();
    wbuf[0] = 16'h003C;
    frame_write(1, 7, 8, 16'h11, 1);
    wbuf[0] = 16'h00F0;
    wbuf[1] = 16'h000F;
    frame_write(1, 7, 8, 16'h10, 2);
    frame_read(1, 7, 8, 16'h10, 2);
    total++;
    if (rbuf[0] !== 16'h00F0) begin bad++; $display("FAIL noburst_w0 got=%h want=00F0", rbuf[0]); end
    total++;
    if (rbuf[1] !== 16'h0000) begin bad++; $display("FAIL noburst_w1 got=%h want=0000", rbuf[1]); end
    frame_read(1, 7, 8, 16'h11, 1);
    total++;
    if (rbuf[0] !== 16'h003C) begin bad++; $display("FAIL noburst_keep got=%h want=003C", rbuf[0]); end
  endtask

  task automatic test_wide();
    wbuf[0] = 16'hBEEF;
    frame_write(2, 4, 16, 16'hA, 1);
    wbuf[0] = 16'h1234;
    frame_write(2, 4, 16, 16'h5, 1);
    frame_read(2, 4, 16, 16'hA, 1);
    total++;
    if (rbuf[0] !== 16'hBEEF) begin bad++; $display("FAIL wide_a got=%h want=BEEF", rbuf[0]); end
    frame_read(2, 4, 16, 16'h5, 1);
    total++;
    if (rbuf[0] !== 16'h1234) begin bad++; $display("FAIL wide_5 got=%h want=1234", rbuf[0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic mi, oe, oe_cmd;
    cs_set(0, 1'b0);
    send_cmd(0, 7, 16'h15, 1'b1, oe_cmd);
    for (int i = 0; i < 3; i++) spi_bit(0, 1'b0, mi, oe);
    total++;
    if (leds0 !== 4'hB) begin bad++; $display("FAIL midrst_pre_leds got=%h want=B", leds0); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (leds0 !== 4'h0 || oe_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state got=leds%h oe%b busy%b want=0/0/0", leds0, oe_w[0], busy_w[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) spi_bit(0, 1'b1, mi, oe);
    total++;
    if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL midrst_lost got=%b want=0", busy_w[0]); end
    cs_set(0, 1'b1);
    frame_read(0, 7, 8, 16'h15, 1);
    total++;
    if (rbuf[0] !== 16'h00A5) begin bad++; $display("FAIL midrst_next got=%h want=00A5", rbuf[0]); end
  endtask

  initial begin
    test_reset();
    test_single_rw();
    test_burst();
    test_abort();
    test_no_burst();
    test_wide();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
